// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared mode encodings and FSM state type for chan_mux_seq
package chan_mux_pkg;
    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_CONT   = 2'b10;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
endpackage

// File: rtl/chan_mux_seq_if.sv
// chan_mux_seq_if: channel data, control and output handshake bundle
//   din/mode/req/sel/en_mask/start/stop/out_ready : driven by the master (producer side)
//   req_ready/out_data/out_ch/out_valid/busy/done/err : driven by the slave (the mux)
interface chan_mux_seq_if #(parameter int N_CH = 8, parameter int W = 1);
    localparam int SEL_W = $clog2(N_CH);
    logic [N_CH*W-1:0] din;
    logic [1:0]        mode;
    logic              req;
    logic [SEL_W-1:0]  sel;
    logic              req_ready;
    logic [N_CH-1:0]   en_mask;
    logic              start;
    logic              stop;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output din, mode, req, sel, en_mask, start, stop, out_ready,
        input  req_ready, out_data, out_ch, out_valid, busy, done, err
    );
    modport slave (
        input  din, mode, req, sel, en_mask, start, stop, out_ready,
        output req_ready, out_data, out_ch, out_valid, busy, done, err
    );
endinterface

// File: rtl/chan_next_pick.sv
// chan_next_pick: next set mask bit above idx (wrapping to lowest), lowest set bit, is_last flag
//   mask    : channel enable mask
//   idx     : current channel index
//   nxt     : next set bit strictly above idx, or lowest set bit when none
//   lowest  : lowest set bit of mask (0 when mask is empty)
//   is_last : no set bit above idx
module chan_next_pick #(parameter int N_CH = 8) (
    input  logic [N_CH-1:0]         mask,
    input  logic [$clog2(N_CH)-1:0] idx,
    output logic [$clog2(N_CH)-1:0] nxt,
    output logic [$clog2(N_CH)-1:0] lowest,
    output logic                    is_last
);
    localparam int SEL_W = $clog2(N_CH);

    // Scanning downward lets the last hit win, leaving the lowest qualifying bit.
    always_comb begin
        lowest  = '0;
        nxt     = '0;
        is_last = 1'b1;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (mask[k]) lowest = SEL_W'(k);
            if (mask[k] && k > int'(idx)) begin
                nxt     = SEL_W'(k);
                is_last = 1'b0;
            end
        end
        if (is_last) nxt = lowest;
    end
endmodule

// File: rtl/chan_mux_seq.sv
// chan_mux_seq: registered N-channel mux with valid/ready output and automatic channel sweep
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of chan_mux_seq_if (channel data, manual request,
//                sweep control, output sample handshake, busy/done/err status)
module chan_mux_seq
    import chan_mux_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int W    = 1
) (
    input logic           clk,
    input logic           rst_n,
    chan_mux_seq_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);

    state_t            state, state_d;
    logic [N_CH-1:0]   mask_q;
    logic [SEL_W-1:0]  ptr, nxt, low, cap_idx;
    logic              is_last, cont_q, stop_q;
    logic              free, sweep_mode, sel_ok, cap, go, rej, fin;
    logic [W-1:0]      cap_data;

    // In IDLE the picker looks at the live mask so the first channel is ready at start.
    chan_next_pick #(.N_CH(N_CH)) u_pick (
        .mask   (state == IDLE ? bus.en_mask : mask_q),
        .idx    (ptr),
        .nxt    (nxt),
        .lowest (low),
        .is_last(is_last)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_d;

    always_comb begin
        free          = !bus.out_valid || bus.out_ready;
        sweep_mode    = bus.mode == MODE_SINGLE || bus.mode == MODE_CONT;
        // Extra bit keeps the range test meaningful when N_CH is a power of two.
        sel_ok        = {1'b0, bus.sel} < (SEL_W + 1)'(N_CH);
        bus.req_ready = state == IDLE && !sweep_mode && free;
        bus.busy      = state != IDLE;
        cap_idx       = state == SCAN ? ptr : bus.sel;
        state_d       = state;
        cap           = 1'b0;
        go            = 1'b0;
        rej           = 1'b0;
        fin           = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req && bus.req_ready) begin
                    cap = sel_ok;
                    rej = !sel_ok;
                end
                if (bus.start && sweep_mode) begin
                    go      = |bus.en_mask;
                    rej     = ~|bus.en_mask;
                    state_d = go ? SCAN : IDLE;
                end
            end
            SCAN: if (free) begin
                cap = 1'b1;
                // A stop arriving on the final capture cycle still ends the sweep here.
                if (is_last && (!cont_q || stop_q || bus.stop)) state_d = DRAIN;
            end
            DRAIN: if (free) begin
                fin     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cap_data = '0;
        for (int k = 0; k < N_CH; k++)
            cap_data = cap_idx == SEL_W'(k) ? bus.din[k*W +: W] : cap_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data  <= '0;
            bus.out_ch    <= '0;
            bus.out_valid <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            mask_q        <= '0;
            ptr           <= '0;
            cont_q        <= 1'b0;
            stop_q        <= 1'b0;
        end else begin
            bus.done      <= fin;
            bus.err       <= rej;
            bus.out_valid <= cap || (bus.out_valid && !bus.out_ready);
            if (cap) begin
                bus.out_data <= cap_data;
                bus.out_ch   <= cap_idx;
            end
            if (go) begin
                mask_q <= bus.en_mask;
                ptr    <= low;
                cont_q <= bus.mode == MODE_CONT;
                stop_q <= 1'b0;
            end else if (state == SCAN) begin
                stop_q <= stop_q | bus.stop;
                if (cap) ptr <= nxt;
            end
        end
    end
endmodule

// File: tb/tb_chan_mux_seq.sv
// tb_chan_mux_seq: directed and randomized checks of chan_mux_seq against a queue-based reference model
module tb_chan_mux_seq;
    localparam int N_CH = 6;
    localparam int W    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    chan_mux_seq_if #(.N_CH(N_CH), .W(W)) bus ();
    chan_mux_seq #(.N_CH(N_CH), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 sweeping, 2 waiting for the last sample to leave.
    // A sweep is a queue of channel numbers still to be emitted in ascending order.
    int              phase;
    bit              m_valid, m_cont, m_stop, m_done, m_err;
    int              m_data, m_ch;
    int              q[$];
    logic [N_CH-1:0] m_mask;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        phase = 0; m_valid = 0; m_data = 0; m_ch = 0; m_done = 0; m_err = 0;
        m_cont = 0; m_stop = 0; m_mask = '0; q.delete();
    endtask

    task automatic fill();
        q.delete();
        for (int k = 0; k < N_CH; k++) if (m_mask[k]) q.push_back(k);
    endtask

    // Called just after a falling edge with inputs already set for the coming rising edge.
    task automatic step();
        bit manual, free, cap, n_done, n_err;
        int ch;
        #1;
        if (!rst_n) model_reset();
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_data",  32'(bus.out_data),  m_data);
        check("out_ch",    32'(bus.out_ch),    m_ch);
        check("busy",      32'(bus.busy),      32'(phase != 0));
        check("done",      32'(bus.done),      32'(m_done));
        check("err",       32'(bus.err),       32'(m_err));
        manual = bus.mode == 2'b00 || bus.mode == 2'b11;
        free   = !m_valid || bus.out_ready;
        check("req_ready", 32'(bus.req_ready), 32'(phase == 0 && manual && free));
        if (rst_n) begin
            cap = 0; ch = 0; n_done = 0; n_err = 0;
            if (phase == 0) begin
                if (manual && bus.req && free) begin
                    if (int'(bus.sel) < N_CH) begin cap = 1; ch = int'(bus.sel); end
                    else n_err = 1;
                end
                if (!manual && bus.start) begin
                    if (bus.en_mask != 0) begin
                        m_mask = bus.en_mask; fill();
                        m_cont = bus.mode == 2'b10; m_stop = 0; phase = 1;
                    end else n_err = 1;
                end
            end else if (phase == 1) begin
                m_stop |= bus.stop;
                if (free) begin
                    ch = q.pop_front(); cap = 1;
                    if (q.size() == 0) begin
                        if (m_cont && !m_stop) fill();
                        else phase = 2;
                    end
                end
            end else if (free) begin
                phase = 0; n_done = 1;
            end
            if (cap) begin m_data = int'(bus.din[ch*W +: W]); m_ch = ch; end
            m_valid = cap || (m_valid && !bus.out_ready);
            m_done  = n_done;
            m_err   = n_err;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        bus.start = 0; bus.req = 0; bus.stop = 0;
        repeat (n) step();
    endtask

    initial begin
        bus.din = '0; bus.mode = 2'b00; bus.req = 0; bus.sel = '0; bus.en_mask = '0;
        bus.start = 0; bus.stop = 0; bus.out_ready = 1;
        model_reset();
        repeat (2) @(negedge clk);
        step();
        rst_n = 1;
        step();
        // manual capture of channel 5, then an out-of-range index
        bus.din = 24'hA0_0000; bus.req = 1; bus.sel = 3'd5; step(); run(2);
        bus.req = 1; bus.sel = 3'd7; step(); run(2);
        // single sweep with free-flowing output
        bus.mode = 2'b01; bus.en_mask = 6'b100101; bus.din = 24'h654321;
        bus.start = 1; step(); run(6);
        // same sweep under back-pressure 1,0,0,1,0,0...
        bus.start = 1; step(); bus.start = 0;
        for (int i = 0; i < 12; i++) begin
            bus.out_ready = (i % 3) == 0;
            bus.din = 24'($urandom);
            step();
        end
        bus.out_ready = 1; run(3);
        // continuous sweep over two channels, stopped part way through
        bus.mode = 2'b10; bus.en_mask = 6'h03; bus.start = 1; step(); run(3);
        bus.stop = 1; step(); run(5);
        // zero-mask start is rejected
        bus.en_mask = '0; bus.start = 1; step(); run(2);
        // reset in the middle of a sweep, then a fresh full sweep
        bus.mode = 2'b01; bus.en_mask = 6'b111110; bus.start = 1; step(); run(2);
        rst_n = 0; step();
        rst_n = 1; bus.start = 1; step(); run(8);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bus.din       = 24'($urandom);
            bus.mode      = 2'($urandom);
            bus.req       = 1'($urandom);
            bus.sel       = 3'($urandom);
            bus.en_mask   = ($urandom_range(0, 7) == 0) ? '0 : 6'($urandom);
            bus.start     = $urandom_range(0, 9) == 0;
            bus.stop      = $urandom_range(0, 15) == 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            rst_n         = $urandom_range(0, 199) != 0;
            step();
        end
        rst_n = 1; run(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
